// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared fetch/decode pipeline constants and register layout
package if_id_stage_pkg;

    localparam int                DATA_W    = 32;
    localparam int                PC_INC    = 4;
    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

    // Register contents of the IF/ID boundary; id_ex reuses the PC fields.
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] pc_plus4;
        logic [DATA_W-1:0] instr;
        logic              valid;
    } if_id_t;

    // Canonical bubble: NOP with zeroed PC fields and valid cleared.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.instr    = NOP_INSTR;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_stage_sat_counter.sv
// rtl/if_id_stage_sat_counter.sv - width-parameterised saturating event counter
module if_id_stage_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         at_max;

    assign at_max = &cnt_q;

    // Count enabled events, sticking at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && !at_max) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Counter state with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with stall/flush; IF_ID_PERF_CNT_EN adds stall/flush counters
module if_id_stage #(
    parameter int                DATA_W    = if_id_stage_pkg::DATA_W,
    parameter int                PC_INC    = if_id_stage_pkg::PC_INC,
    parameter logic [DATA_W-1:0] NOP_INSTR = if_id_stage_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              hold,
    input  logic              flush,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] pc_plus4_out,
    output logic [DATA_W-1:0] instr_out,
    output logic              valid_out
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic [DATA_W-1:0] pc_q,       pc_d;
    logic [DATA_W-1:0] pc_plus4_q, pc_plus4_d;
    logic [DATA_W-1:0] instr_q,    instr_d;
    logic              valid_q,    valid_d;

    // Next state: flush beats hold beats load; inputs are only looked at on load,
    // so unknown fetch data during a stall or redirect never reaches decode.
    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (flush) begin
            pc_d       = '0;
            pc_plus4_d = '0;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else if (!hold) begin
            pc_d       = pc_in;
            pc_plus4_d = pc_in + DATA_W'(PC_INC);
            instr_d    = instr_in;
            valid_d    = 1'b1;
        end
    end

    // Pipeline register; reset empties the slot to a bubble immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign pc_out       = pc_q;
    assign pc_plus4_out = pc_plus4_q;
    assign instr_out    = instr_q;
    assign valid_out    = valid_q;

`ifdef IF_ID_PERF_CNT_EN
    logic stall_ev;

    // A stall that coincides with a flush is accounted as a flush only.
    assign stall_ev = hold && !flush;

    if_id_stage_sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (stall_ev),
        .cnt_o (stall_cnt)
    );

    if_id_stage_sat_counter #(.W(32)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst),
        .en_i  (flush),
        .cnt_o (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic        hold;
    logic        flush;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic [31:0] instr_out;
    logic        valid_out;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .hold         (hold),
        .flush        (flush),
        .pc_out       (pc_out),
        .pc_plus4_out (pc_plus4_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out)
`ifdef IF_ID_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference: what decode should be holding right now.
    logic [31:0] m_pc;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;

    typedef struct {
        logic        hold;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] epc, input logic [31:0] epc4,
                            input logic [31:0] einstr, input logic evalid);
        chk({tag, ".pc"},       pc_out,       epc);
        chk({tag, ".pc_plus4"}, pc_plus4_out, epc4);
        chk({tag, ".instr"},    instr_out,    einstr);
        chk({tag, ".valid"},    {31'd0, valid_out}, {31'd0, evalid});
    endtask

    function automatic void model_reset();
        m_pc = 32'd0; m_pc4 = 32'd0; m_instr = 32'd0; m_valid = 1'b0;
    endfunction

    // Rising-edge rule: reset, else flush empties, else stall keeps, else capture.
    function automatic void model_edge();
        if (!rst)             model_reset();
        else if (flush)       model_reset();
        else if (!hold) begin
            m_pc    = pc_in;
            m_pc4   = pc_in + 32'd4;
            m_instr = instr_in;
            m_valid = 1'b1;
        end
    endfunction

    task automatic drive(input logic h, input logic f, input logic [31:0] pc, input logic [31:0] ins);
        @(negedge clk);
        hold = h; flush = f; pc_in = pc; instr_in = ins;
    endtask

    task automatic edge_model();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic add(input logic h, input logic f, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] epc, input logic [31:0] epc4, input logic [31:0] ei,
                       input logic ev);
        vec_t v;
        v.hold = h; v.flush = f; v.pc = pc; v.instr = ins;
        v.e_pc = epc; v.e_pc4 = epc4; v.e_instr = ei; v.e_valid = ev;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b0; hold = 1'b0; flush = 1'b0; pc_in = 32'h1234; instr_in = 32'h5678;
        model_reset();

        add(0, 0, 32'h0000_0000, 32'h8C08_0004, 32'h0000_0000, 32'h0000_0004, 32'h8C08_0004, 1);
        add(0, 0, 32'h0000_0010, 32'h0109_5020, 32'h0000_0010, 32'h0000_0014, 32'h0109_5020, 1);
        add(1, 0, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0014, 32'h0109_5020, 1);
        add(1, 0, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0014, 32'h0109_5020, 1);
        add(1, 0, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0014, 32'h0109_5020, 1);
        add(0, 0, 32'h0000_0014, 32'hDEAD_BEEF, 32'h0000_0014, 32'h0000_0018, 32'hDEAD_BEEF, 1);
        add(1, 1, 32'h0000_0018, 32'h1234_5678, 32'h0,         32'h0,         32'h0,         0);
        add(1, 0, 32'h0000_001C, 32'hAAAA_5555, 32'h0,         32'h0,         32'h0,         0);
        add(0, 1, 32'h0000_0020, 32'h1111_1111, 32'h0,         32'h0,         32'h0,         0);
        add(0, 1, 32'h0000_0024, 32'h2222_2222, 32'h0,         32'h0,         32'h0,         0);
        add(0, 0, 32'h0000_0028, 32'h3333_3333, 32'h0000_0028, 32'h0000_002C, 32'h3333_3333, 1);
        add(0, 0, 32'hFFFF_FFFC, 32'h0000_000C, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C, 1);
        add(1, 0, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_000C, 1);
        add(0, 1, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 32'h0,         32'h0,         32'h0,         0);

        // Reset state while rst is held low across an edge.
        @(posedge clk); #1;
        chk_outs("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        @(negedge clk); rst = 1'b1;

        // Directed table: load, stall, flush priority, bubble under hold, wrap, X under hold/flush.
        foreach (vecs[i]) begin
            drive(vecs[i].hold, vecs[i].flush, vecs[i].pc, vecs[i].instr);
            edge_model();
            chk_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_pc4, vecs[i].e_instr, vecs[i].e_valid);
        end

        // Asynchronous reset mid-cycle with a loaded slot, asserted during hold+flush.
        drive(0, 0, 32'h0000_0040, 32'h2008_0007);
        edge_model();
        chk_outs("preload", 32'h40, 32'h44, 32'h2008_0007, 1'b1);
        @(negedge clk); #2;
        rst = 1'b0; hold = 1'b1; flush = 1'b1;
        #1;
        model_reset();
        chk_outs("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
        drive(0, 0, 32'h0000_0000, 32'h8C08_0004);
        rst = 1'b1;
        edge_model();
        chk_outs("post_rst", 32'h0, 32'h4, 32'h8C08_0004, 1'b1);

        // Randomized traffic against the reference model, with occasional resets.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, pc, $urandom);
            rst = ($urandom_range(0, 49) != 0);
            edge_model();
            chk_outs($sformatf("rnd%0d", n), m_pc, m_pc4, m_instr, m_valid);
        end
        @(negedge clk); rst = 1'b1;

`ifdef IF_ID_PERF_CNT_EN
        // Counter behaviour: reset clear, counting rules, saturation, clear again.
        @(negedge clk); rst = 1'b0; hold = 1'b0; flush = 1'b0;
        #1;
        chk("stall_cnt.rst", stall_cnt, 32'd0);
        chk("flush_cnt.rst", flush_cnt, 32'd0);
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 5; k++) drive(1, 0, 32'h0, 32'h0);
        for (int k = 0; k < 2; k++) drive(0, 1, 32'h0, 32'h0);
        drive(1, 1, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        #1;
        chk("stall_cnt.count", stall_cnt, 32'd5);
        chk("flush_cnt.count", flush_cnt, 32'd3);
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        force dut.u_flush_cnt.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.cnt_q;
        release dut.u_flush_cnt.cnt_q;
        for (int k = 0; k < 3; k++) drive(1, 0, 32'h0, 32'h0);
        drive(0, 1, 32'h0, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        #1;
        chk("stall_cnt.sat", stall_cnt, 32'hFFFF_FFFF);
        chk("flush_cnt.sat", flush_cnt, 32'hFFFF_FFFF);
        rst = 1'b0;
        #1;
        chk("stall_cnt.clr", stall_cnt, 32'd0);
        chk("flush_cnt.clr", flush_cnt, 32'd0);
        @(negedge clk); rst = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch-to-decode pipeline register. Sits directly downstream of the program counter and instruction memory.
- Captures the fetched instruction, its PC and PC+4 each cycle. Holds on a hazard stall and squashes to a bubble on a branch/jump flush.
- Drives the decode stage and the hazard/forwarding logic.

Parameters:
- DATA_W, 32, width of PC and instruction words.
- PC_INC, 4, byte increment added to the captured PC to form pc_plus4_out.
- NOP_INSTR, 32'h00000000, encoding loaded on flush and reset (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- pc_in  input  DATA_W  PC of the instruction being fetched (PC register output).
- instr_in  input  DATA_W  instruction memory read data for pc_in.
- hold  input  1  1 = stall: keep current contents. Same polarity as the PC register's PCWrite hold; both are driven by the hazard unit.
- flush  input  1  1 = squash: load bubble (branch/jump taken in a later stage).
- pc_out  output  DATA_W  registered PC of the decode-stage instruction.
- pc_plus4_out  output  DATA_W  registered pc_in + PC_INC.
- instr_out  output  DATA_W  registered instruction.
- valid_out  output  1  1 = instr_out is a real instruction; 0 = bubble.

Behaviour:
- Reset (rst==0, async, immediate, independent of clk):
  - pc_out = 0, pc_plus4_out = 0, instr_out = NOP_INSTR, valid_out = 0.
- Reset mid-stall or mid-flush: reset wins unconditionally. The first rising edge after rst returns to 1 performs a normal load.
- Per rising edge with rst==1, priority is flush > hold > load:
  - Flush: instr_out = NOP_INSTR, valid_out = 0, pc_out and pc_plus4_out = 0. This applies even if hold==1 in the same cycle, so a stalled slot is never kept alive across a redirect.
  - Hold (flush==0): all outputs keep their values; no input is sampled.
  - Load (hold==0, flush==0): pc_out = pc_in, pc_plus4_out = pc_in + PC_INC (modulo 2^DATA_W, carry discarded), instr_out = instr_in, valid_out = 1.
- Latency: exactly 1 cycle from pc_in/instr_in to the outputs. No combinational path from any input to any output.
- Wrap-around: pc_in = 32'hFFFFFFFC gives pc_plus4_out = 32'h00000000.
- A bubble under hold stays a bubble (valid_out stays 0).
- Consecutive flushes keep the register in the bubble state.
- Inputs that are X while hold==1 or flush==1 must not propagate to the outputs.

Optional Feature:
- Macro IF_ID_PERF_CNT_EN.
- When defined, adds two extra output ports:
  - stall_cnt (32): increments on each edge where hold==1 and flush==0.
  - flush_cnt (32): increments on each edge where flush==1.
- Both counters reset to 0 on rst==0 and saturate at 32'hFFFFFFFF (no wrap).
- When undefined, these ports and registers do not exist and the module is port-identical to the list above.

Decomposition:
- Shared pipeline package holds:
  - DATA_W, PC_INC and NOP_INSTR constants.
  - A packed if_id_t struct {pc, pc_plus4, instr, valid}, reused by the id_ex stage for its PC fields.
- One sub-module is natural: sat_counter (width-parameterised, enable, async active-low reset, saturating). It is instantiated twice under IF_ID_PERF_CNT_EN and nothing outside the macro uses it.

Test Plan:
- Reset: rst=0 mid-cycle with outputs loaded → outputs go immediately (before the next edge) to pc=0, pc_plus4=0, instr=0, valid=0. Release rst, then pc_in=0x0, instr_in=0x8C080004 → next edge gives pc_out=0x0, pc_plus4_out=0x4, instr_out=0x8C080004, valid_out=1.
- Stall: load pc=0x10/instr=0x01095020, then hold=1 for 3 cycles while pc_in=0x14, instr_in=0xDEADBEEF → outputs stay 0x10/0x14/0x01095020/1. On release, load 0x14.
- Flush priority: hold=1 and flush=1 on the same edge → instr_out=0, valid_out=0, pc_out=0. Next edge with hold=0 loads pc_in normally.
- Wrap: pc_in=0xFFFFFFFC → pc_plus4_out=0x00000000, pc_out=0xFFFFFFFC.
- Perf counters (macro defined): 5 hold cycles, 2 flush cycles, 1 hold+flush cycle → stall_cnt=5, flush_cnt=3. Forced preload near max saturates at 0xFFFFFFFF. Reset clears both counters to 0.
